// File: rtl/load_store_unit.sv
// Load/store unit between the single-cycle MIPS datapath and a word-organised
// data memory with combinational read and synchronous write. Sub-word stores
// are done as read-modify-write on the word captured at accept time.
module load_store_unit #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned BIG_ENDIAN  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        loadSigned,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] loadData,
    output logic        memWrite,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    localparam int unsigned DATA_W = 32;
    localparam logic [32:0] LIMIT  = 33'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_done;
    logic                r_fault;
    logic                r_mem_write;
    logic [DATA_W-1:0]   r_load_data;

    logic                w_done_next;
    logic                w_fault_next;
    logic                w_mem_write_next;
    logic [DATA_W-1:0]   w_load_data_next;

    // Request context captured at accept
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_size;

    logic                w_accept;
    logic                w_fault;
    logic [4:0]          w_rd_shift_b;
    logic [4:0]          w_rd_shift_h;
    logic [7:0]          w_rd_byte;
    logic [15:0]         w_rd_half;
    logic [DATA_W-1:0]   w_load_ext;
    logic [4:0]          w_st_shift_b;
    logic [4:0]          w_st_shift_h;
    logic [DATA_W-1:0]   w_mask_b;
    logic [DATA_W-1:0]   w_mask_h;
    logic [DATA_W-1:0]   w_merged;

    assign w_accept = (r_state == IDLE) && req;

    // Alignment, reserved-size and range checks on the incoming request
    always_comb begin
        w_fault = 1'b0;
        if (size == 2'b11)                               w_fault = 1'b1;
        if ((size == SZ_HALF) && address[0])             w_fault = 1'b1;
        if ((size == SZ_WORD) && (address[1:0] != 2'b00)) w_fault = 1'b1;
        if ({1'b0, address} >= LIMIT)                    w_fault = 1'b1;
    end

    // Lane selection and extension of the combinational read word
    always_comb begin
        if (BIG_ENDIAN != 0) begin
            w_rd_shift_b = {~address[1:0], 3'b000};
            w_rd_shift_h = {~address[1], 4'b0000};
        end else begin
            w_rd_shift_b = {address[1:0], 3'b000};
            w_rd_shift_h = {address[1], 4'b0000};
        end
        w_rd_byte = 8'(memReadData >> w_rd_shift_b);
        w_rd_half = 16'(memReadData >> w_rd_shift_h);
        case (size)
            SZ_BYTE: w_load_ext = loadSigned ? {{24{w_rd_byte[7]}}, w_rd_byte}
                                             : {24'b0, w_rd_byte};
            SZ_HALF: w_load_ext = loadSigned ? {{16{w_rd_half[15]}}, w_rd_half}
                                             : {16'b0, w_rd_half};
            default: w_load_ext = memReadData;
        endcase
    end

    // Merge store data into the captured word for sub-word stores
    always_comb begin
        if (BIG_ENDIAN != 0) begin
            w_st_shift_b = {~r_addr[1:0], 3'b000};
            w_st_shift_h = {~r_addr[1], 4'b0000};
        end else begin
            w_st_shift_b = {r_addr[1:0], 3'b000};
            w_st_shift_h = {r_addr[1], 4'b0000};
        end
        w_mask_b = 32'h0000_00FF << w_st_shift_b;
        w_mask_h = 32'h0000_FFFF << w_st_shift_h;
        case (r_size)
            SZ_BYTE: w_merged = (r_rdata & ~w_mask_b) | ({4{r_wdata[7:0]}} & w_mask_b);
            SZ_HALF: w_merged = (r_rdata & ~w_mask_h) | ({2{r_wdata[15:0]}} & w_mask_h);
            default: w_merged = r_wdata;
        endcase
    end

    // Next-state and next registered-output decode
    always_comb begin
        w_state_next     = r_state;
        w_done_next      = 1'b0;
        w_fault_next     = 1'b0;
        w_mem_write_next = 1'b0;
        w_load_data_next = r_load_data;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_fault) begin
                        w_state_next = DONE;
                        w_done_next  = 1'b1;
                        w_fault_next = 1'b1;
                    end else if (we) begin
                        w_state_next     = STORE;
                        w_mem_write_next = 1'b1;
                    end else begin
                        w_state_next     = DONE;
                        w_done_next      = 1'b1;
                        w_load_data_next = w_load_ext;
                    end
                end
            end
            STORE: begin
                w_state_next = DONE;
                w_done_next  = 1'b1;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_mem_write <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state     <= w_state_next;
            r_done      <= w_done_next;
            r_fault     <= w_fault_next;
            r_mem_write <= w_mem_write_next;
            r_load_data <= w_load_data_next;
        end
    end

    // Capture request context on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_size  <= '0;
        end else if (w_accept) begin
            r_addr  <= address;
            r_wdata <= storeData;
            r_rdata <= memReadData;
            r_size  <= size;
        end
    end

    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign fault        = r_fault;
    assign memWrite     = r_mem_write;
    assign loadData     = r_load_data;
    assign memWriteData = w_merged;
    assign memAddress   = (r_state == IDLE) ? {address[31:2], 2'b00}
                                            : {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-organised memory model.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        loadSigned;
    logic [31:0] address;
    logic [31:0] storeData;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] loadData;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    logic [31:0] mem [0:1023];

    int checks;
    int errors;

    load_store_unit #(.DEPTH_WORDS(1024), .BIG_ENDIAN(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .we           (we),
        .size         (size),
        .loadSigned   (loadSigned),
        .address      (address),
        .storeData    (storeData),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .loadData     (loadData),
        .memWrite     (memWrite),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memReadData  (memReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memReadData = mem[memAddress[11:2]];

    always @(posedge clk) begin
        if (memWrite) mem[memAddress[11:2]] <= memWriteData;
    end

    task automatic present(input logic w, input logic [1:0] s, input logic sg,
                           input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req        = 1'b1;
        we         = w;
        size       = s;
        loadSigned = sg;
        address    = a;
        storeData  = d;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic do_load(input string nm, input logic [1:0] s, input logic sg,
                           input logic [31:0] a, input logic [31:0] exp);
        present(1'b0, s, sg, a, 32'h0);
        checks++;
        if (done !== 1'b1 || fault !== 1'b0 || memWrite !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: done=%b fault=%b memWrite=%b busy=%b, want 1 0 0 1",
                     nm, done, fault, memWrite, busy);
        end
        checks++;
        if (loadData !== exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h", nm, loadData, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b want 0 0", nm, busy, done);
        end
    endtask

    task automatic do_store(input string nm, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_wd, input logic [31:0] exp_ma);
        present(1'b1, s, 1'b0, a, d);
        checks++;
        if (memWrite !== 1'b1 || done !== 1'b0 || memWriteData !== exp_wd || memAddress !== exp_ma) begin
            errors++;
            $display("FAIL %s write: memWrite=%b done=%b wd=%h ma=%h want 1 0 %h %h",
                     nm, memWrite, done, memWriteData, memAddress, exp_wd, exp_ma);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || fault !== 1'b0 || memWrite !== 1'b0) begin
            errors++;
            $display("FAIL %s done: done=%b fault=%b memWrite=%b want 1 0 0",
                     nm, done, fault, memWrite);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_fault(input string nm, input logic w, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] prev_ld);
        present(w, s, 1'b0, a, 32'hFFFF_FFFF);
        checks++;
        if (done !== 1'b1 || fault !== 1'b1 || memWrite !== 1'b0 || loadData !== prev_ld) begin
            errors++;
            $display("FAIL %s: done=%b fault=%b memWrite=%b ld=%h want 1 1 0 %h",
                     nm, done, fault, memWrite, loadData, prev_ld);
        end
        @(posedge clk); #1;
        checks++;
        if (memWrite !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s after: memWrite=%b busy=%b done=%b want 0 0 0",
                     nm, memWrite, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || memWrite !== 1'b0 || loadData !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b fault=%b memWrite=%b ld=%h want all 0",
                     busy, done, fault, memWrite, loadData);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_loads();
        do_load("LB_13",  2'b00, 1'b1, 32'h13, 32'hFFFF_FFBB);
        do_load("LBU_11", 2'b00, 1'b0, 32'h11, 32'h0000_0099);
        do_load("LB_10",  2'b00, 1'b1, 32'h10, 32'hFFFF_FF88);
        do_load("LH_12",  2'b01, 1'b1, 32'h12, 32'hFFFF_AABB);
        do_load("LHU_10", 2'b01, 1'b0, 32'h10, 32'h0000_8899);
        do_load("LW_10",  2'b10, 1'b0, 32'h10, 32'h8899_AABB);
    endtask

    task automatic test_stores();
        do_store("SB_11", 2'b00, 32'h11, 32'h1234_5677, 32'h8877_AABB, 32'h10);
        do_load("LW_after_SB", 2'b10, 1'b0, 32'h10, 32'h8877_AABB);
        do_store("SH_12", 2'b01, 32'h12, 32'h0000_CAFE, 32'h8877_CAFE, 32'h10);
        do_store("SW_14", 2'b10, 32'h14, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h14);
        do_load("LW_after_SH", 2'b10, 1'b0, 32'h10, 32'h8877_CAFE);
        do_load("LBU_14", 2'b00, 1'b0, 32'h14, 32'h0000_00DE);
    endtask

    task automatic test_faults();
        do_fault("F_SH_11",  1'b1, 2'b01, 32'h11,   32'h0000_00DE);
        do_fault("F_LW_12",  1'b0, 2'b10, 32'h12,   32'h0000_00DE);
        do_fault("F_SZ11",   1'b0, 2'b11, 32'h10,   32'h0000_00DE);
        do_fault("F_LW_1000",1'b0, 2'b10, 32'h1000, 32'h0000_00DE);
        checks++;
        if (mem[4] !== 32'h8877_CAFE) begin
            errors++;
            $display("FAIL fault_no_write: mem[0x10]=%h want 8877cafe", mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        present(1'b1, 2'b10, 1'b0, 32'h20, 32'h0BAD_F00D);
        // hold a request through STORE and DONE; it must be dropped
        we = 1'b0; size = 2'b10; address = 32'h10; req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b busy=%b want 1 1", done, busy);
        end
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored: done=%b busy=%b want 0 0", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || loadData !== 32'h0000_00DE || mem[8] !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL b2b_state: done=%b ld=%h mem20=%h want 0 000000de 0badf00d",
                     done, loadData, mem[8]);
        end
    endtask

    task automatic test_reset_in_store();
        present(1'b1, 2'b10, 1'b0, 32'h18, 32'h1111_1111);
        checks++;
        if (memWrite !== 1'b1) begin
            errors++;
            $display("FAIL rst_store_pre: memWrite=%b want 1", memWrite);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (memWrite !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || loadData !== 32'h0) begin
            errors++;
            $display("FAIL rst_store: memWrite=%b busy=%b done=%b ld=%h want 0 0 0 0",
                     memWrite, busy, done, loadData);
        end
        // simultaneous reset and request: the request is dropped
        req = 1'b1; we = 1'b0; size = 2'b10; address = 32'h10;
        @(posedge clk); #1;
        req = 1'b0;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_req: busy=%b done=%b want 0 0", busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || loadData !== 32'h0) begin
            errors++;
            $display("FAIL rst_req_after: busy=%b done=%b ld=%h want 0 0 0", busy, done, loadData);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req = 1'b0; we = 1'b0; size = 2'b00; loadSigned = 1'b0;
        address = 32'h0; storeData = 32'h0; reset = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899_AABB;

        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_back_to_back();
        test_reset_in_store();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
